// File: rtl/uart_hex_display.sv
// ASCII-hex line parser feeding a 4-digit multiplexed 7-segment display.
// Typed hex digits build a 16-bit value; CR/LF commits it, any other byte flags an error.
module uart_hex_display #(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic        clk50m,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] disp_value,
    output logic        commit,
    output logic        err,
    output logic [7:0]  seg7,
    output logic [3:0]  seg_cs
);

    // Handshake: rx_data is consumed on every cycle rx_valid=1; there is no ready,
    // the parser accepts one byte per cycle unconditionally.

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pending_q, pending_d;
    logic [2:0]  count_q, count_d;
    logic [15:0] disp_q, disp_d;
    logic        commit_d, err_d;
    logic        is_hex, is_eol;
    logic [3:0]  nib;

    logic [CW-1:0] scan_cnt;
    logic [1:0]    idx, idx_next;
    logic [3:0]    nib_sel;
    logic          blank;

    function automatic logic [7:0] hex_glyph(input logic [3:0] n);
        logic [7:0] g;
        case (n)
            4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
            4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
            4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
            4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
        endcase
        return g;
    endfunction

    always_comb begin
        is_hex = 1'b0;
        nib    = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            is_hex = 1'b1;
            nib    = rx_data[3:0];
        end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                     (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
            is_hex = 1'b1;
            nib    = rx_data[3:0] + 4'd9;
        end
        is_eol = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        disp_d    = disp_q;
        commit_d  = 1'b0;
        err_d     = 1'b0;
        if (rx_valid) begin
            case (state_q)
                IDLE: begin
                    if (is_hex) begin
                        pending_d = {12'h000, nib};
                        count_d   = 3'd1;
                        state_d   = COLLECT;
                    end else if (!is_eol) begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    if (is_hex) begin
                        // Shifting keeps the last four digits typed; count saturates.
                        pending_d = {pending_q[11:0], nib};
                        count_d   = (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
                    end else begin
                        if (is_eol) begin
                            disp_d   = pending_q;
                            commit_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                        pending_d = 16'h0000;
                        count_d   = 3'd0;
                        state_d   = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk50m) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= 16'h0000;
            count_q   <= 3'd0;
            disp_q    <= 16'h0000;
            commit    <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            disp_q    <= disp_d;
            commit    <= commit_d;
            err       <= err_d;
        end
    end

    assign disp_value = disp_q;

    // Segment data and select change together, so a lit digit never shows a stale glyph.
    always_comb begin
        idx_next = idx + 2'd1;
        nib_sel  = disp_q[{idx_next, 2'b00} +: 4];
        blank    = BLANK_LZ && (idx_next != 2'd0) &&
                   ((disp_q >> {idx_next, 2'b00}) == 16'h0000);
    end

    always_ff @(posedge clk50m) begin
        if (reset) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
            seg7     <= 8'hFF;
            seg_cs   <= 4'hF;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= idx_next;
            seg_cs   <= ~(4'b0001 << idx_next);
            seg7     <= blank ? 8'hFF : hex_glyph(nib_sel);
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_hex_display.sv
// Bench for uart_hex_display: two instances (leading zeros shown / blanked) driven by the
// same byte stream and compared every cycle against a behavioural model.
module tb_uart_hex_display;

  localparam int SCAN_DIV = 4;

  // ---------------- clock / reset ----------------
  logic        clk50m = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] disp_value0, disp_value1;
  logic        commit0, commit1, err0, err1;
  logic [7:0]  seg7_0, seg7_1;
  logic [3:0]  seg_cs0, seg_cs1;

  always #5 clk50m = ~clk50m;

  uart_hex_display #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b0)) dut0 (
    .clk50m(clk50m), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .disp_value(disp_value0), .commit(commit0), .err(err0),
    .seg7(seg7_0), .seg_cs(seg_cs0)
  );

  uart_hex_display #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut1 (
    .clk50m(clk50m), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .disp_value(disp_value1), .commit(commit1), .err(err1),
    .seg7(seg7_1), .seg_cs(seg_cs1)
  );

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic [15:0] m_disp;
  logic [3:0]  m_typed[$];
  bit          m_collect;
  int          m_k;
  logic        e_commit, e_err;
  logic [7:0]  e_seg7_0, e_seg7_1;
  logic [3:0]  e_cs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int hex_val(input logic [7:0] c);
    string digits = "0123456789abcdefABCDEF";
    for (int i = 0; i < digits.len(); i++)
      if (digits[i] == c) return (i < 16) ? i : i - 6;
    return -1;
  endfunction

  function automatic logic [15:0] typed_value();
    logic [15:0] v = 16'h0;
    foreach (m_typed[i]) v = v * 16 + 16'(m_typed[i]);
    return v;
  endfunction

  // Model of what one clock edge does, applied to pre-edge model state.
  task automatic model_edge(input logic r, input logic v, input logic [7:0] d);
    logic [15:0] old_disp;
    int n, idx, slot;
    e_commit = 1'b0;
    e_err    = 1'b0;
    if (r) begin
      m_disp = 16'h0; m_typed.delete(); m_collect = 0; m_k = 0;
      e_seg7_0 = 8'hFF; e_seg7_1 = 8'hFF; e_cs = 4'hF;
      return;
    end
    old_disp = m_disp;
    m_k++;
    if (m_k % SCAN_DIV == 0) begin
      slot = m_k / SCAN_DIV;
      idx  = slot % 4;
      e_cs = ~(4'(1 << idx));
      e_seg7_0 = glyph[(old_disp >> (4 * idx)) & 16'hF];
      if (idx > 0 && (old_disp >> (4 * idx)) == 0) e_seg7_1 = 8'hFF;
      else e_seg7_1 = e_seg7_0;
    end
    if (v) begin
      n = hex_val(d);
      if (n >= 0) begin
        m_typed.push_back(4'(n));
        if (m_typed.size() > 4) void'(m_typed.pop_front());
        m_collect = 1;
      end else if (d == 8'h0D || d == 8'h0A) begin
        if (m_collect) begin
          m_disp = typed_value();
          e_commit = 1'b1;
          exp_q.push_back(m_disp);
          m_typed.delete();
          m_collect = 0;
        end
      end else begin
        e_err = 1'b1;
        m_typed.delete();
        m_collect = 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input logic r, input logic v, input logic [7:0] d);
    logic [15:0] got_val;
    reset = r; rx_valid = v; rx_data = d;
    @(posedge clk50m);
    model_edge(r, v, d);
    #1;
    check("disp0", disp_value0, m_disp);
    check("disp1", disp_value1, m_disp);
    check("commit0", commit0, e_commit);
    check("commit1", commit1, e_commit);
    check("err0", err0, e_err);
    check("err1", err1, e_err);
    check("seg7_0", seg7_0, e_seg7_0);
    check("seg7_1", seg7_1, e_seg7_1);
    check("seg_cs0", seg_cs0, e_cs);
    check("seg_cs1", seg_cs1, e_cs);
    if (commit0) begin
      if (exp_q.size() == 0) check("unexpected_commit", 1, 0);
      else begin
        got_val = exp_q.pop_front();
        check("commit_value", disp_value0, got_val);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'($urandom_range(0, 255)));
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) tick(1'b0, 1'b1, s[i]);
  endtask

  function automatic logic [7:0] rand_byte();
    string hexs = "0123456789ABCDEFabcdef";
    int r = $urandom_range(0, 9);
    if (r <= 5) return hexs[$urandom_range(0, 21)];
    if (r == 6) return 8'h0D;
    if (r == 7) return 8'h0A;
    return 8'($urandom_range(0, 255));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    model_edge(1'b1, 1'b0, 8'h00);
    // T1: reset state and scan start-up
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'h00);
    check("t1_seg7", seg7_0, 8'hFF);
    check("t1_cs", seg_cs0, 4'hF);
    check("t1_disp", disp_value0, 16'h0);
    idle(4);
    check("t1_first_cs", seg_cs0, 4'b1101);
    check("t1_first_seg7", seg7_0, 8'hC0);
    idle(12);
    check("t1_wrap_cs", seg_cs0, 4'b1110);

    // T2
    send_str("12aF");
    tick(1'b0, 1'b1, 8'h0D);
    check("t2_commit", commit0, 1'b1);
    check("t2_disp", disp_value0, 16'h12AF);
    idle(20);

    // T3: overflow keeps last four, lone LF ignored
    send_str("12345");
    tick(1'b0, 1'b1, 8'h0A);
    check("t3_disp", disp_value0, 16'h2345);
    tick(1'b0, 1'b1, 8'h0A);
    check("t3_lf_commit", commit0, 1'b0);
    check("t3_lf_err", err0, 1'b0);

    // T4: invalid char discards the value
    send_str("12G");
    check("t4_err", err0, 1'b1);
    tick(1'b0, 1'b1, 8'h0D);
    check("t4_commit", commit0, 1'b0);
    check("t4_disp", disp_value0, 16'h2345);

    // T5: reset before the terminator
    send_str("7");
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'h0D);
    check("t5_disp", disp_value0, 16'h0);
    check("t5_commit", commit0, 1'b0);

    // T6: blanking instance after "5" CR
    send_str("5");
    tick(1'b0, 1'b1, 8'h0D);
    check("t6_disp", disp_value1, 16'h0005);
    idle(20);

    // CR+LF pair: one commit only
    send_str("beef");
    tick(1'b0, 1'b1, 8'h0D);
    tick(1'b0, 1'b1, 8'h0A);
    check("crlf_second", commit0, 1'b0);
    idle(16);

    // Randomized traffic with gaps and rare resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) tick(1'b1, 1'b0, 8'h00);
      else if ($urandom_range(0, 3) == 0) tick(1'b0, 1'b0, 8'h00);
      else tick(1'b0, 1'b1, rand_byte());
    end
    idle(16);

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
